// File: rtl/delay_scheduler.sv
// Round-robin scheduler sharing one delay counter among four requesters.
// Optional macro DELAY_SCHED_PRESCALE_EN divides count ticks by 16.
module delay_scheduler #(
  parameter int WIDTH = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] delay,
  output logic [3:0]         grant,
  output logic [3:0]         done,
  output logic               busy,
  output logic [WIDTH-1:0]   count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_r;
  state_t           next_state_s;
  logic [1:0]       sel_r;
  logic [1:0]       last_grant_r;
  logic [WIDTH-1:0] target_r;
  logic [3:0]       grant_r;
  logic [3:0]       done_r;
  logic             busy_r;
  logic [WIDTH-1:0] count_r;

  logic [1:0]       pick_s;
  logic [1:0]       next_sel_s;
  logic [1:0]       next_last_s;
  logic [WIDTH-1:0] next_target_s;
  logic [3:0]       next_grant_s;
  logic [3:0]       next_done_s;
  logic             next_busy_s;
  logic [WIDTH-1:0] next_count_s;
  logic [WIDTH-1:0] sel_delay_s;
  logic             req_sel_s;
  logic             tick_s;

  // First requester found searching upward from last + 1, wrapping mod 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] res;
    logic       found;
    res   = last + 2'd1;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = last + 2'(i + 1);
      if (!found && r[idx]) begin
        res   = idx;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return res;
  endfunction

  assign pick_s      = rr_pick(req, last_grant_r);
  assign req_sel_s   = req[sel_r];
  assign sel_delay_s = delay[sel_r*WIDTH +: WIDTH];

  assign grant = grant_r;
  assign done  = done_r;
  assign busy  = busy_r;
  assign count = count_r;

`ifdef DELAY_SCHED_PRESCALE_EN
  logic [3:0] prescale_r;

  assign tick_s = (prescale_r == 4'd15);

  // Free-running divide-by-16 while counting, restarted for each job.
  always_ff @(posedge clock) begin
    if (reset) begin
      prescale_r <= 4'd0;
    end else if (state_r == LOAD) begin
      prescale_r <= 4'd0;
    end else if (state_r == COUNT) begin
      prescale_r <= prescale_r + 4'd1;
    end else begin
      prescale_r <= prescale_r;
    end
  end
`else
  assign tick_s = 1'b1;
`endif

  // State and all registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= IDLE;
      sel_r        <= 2'd0;
      last_grant_r <= 2'd3;
      target_r     <= '0;
      grant_r      <= 4'd0;
      done_r       <= 4'd0;
      busy_r       <= 1'b0;
      count_r      <= '0;
    end else begin
      state_r      <= next_state_s;
      sel_r        <= next_sel_s;
      last_grant_r <= next_last_s;
      target_r     <= next_target_s;
      grant_r      <= next_grant_s;
      done_r       <= next_done_s;
      busy_r       <= next_busy_s;
      count_r      <= next_count_s;
    end
  end

  // Next-state decode; a dropped req on the owner aborts before anything else.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (req != 4'd0) next_state_s = LOAD;
        else             next_state_s = IDLE;
      end
      LOAD: begin
        if (!req_sel_s)                       next_state_s = IDLE;
        else if (sel_delay_s == WIDTH'(0))    next_state_s = DONE;
        else                                  next_state_s = COUNT;
      end
      COUNT: begin
        if (!req_sel_s)                                       next_state_s = IDLE;
        else if (tick_s && (count_r + WIDTH'(1) == target_r)) next_state_s = DONE;
        else                                                  next_state_s = COUNT;
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Next values of the registered outputs and job bookkeeping.
  always_comb begin
    next_sel_s    = sel_r;
    next_last_s   = last_grant_r;
    next_target_s = target_r;
    next_grant_s  = grant_r;
    next_done_s   = 4'd0;
    next_busy_s   = (next_state_s != IDLE);
    next_count_s  = count_r;
    case (state_r)
      IDLE: begin
        if (next_state_s == LOAD) begin
          next_sel_s   = pick_s;
          next_grant_s = 4'b0001 << pick_s;
        end else begin
          next_grant_s = 4'd0;
        end
      end
      LOAD: begin
        if (next_state_s == IDLE) begin
          next_grant_s = 4'd0;
          next_last_s  = sel_r;
        end else begin
          next_target_s = sel_delay_s;
          next_count_s  = '0;
          if (next_state_s == DONE) next_done_s = grant_r;
          else                      next_done_s = 4'd0;
        end
      end
      COUNT: begin
        if (next_state_s == IDLE) begin
          next_grant_s = 4'd0;
          next_last_s  = sel_r;
        end else begin
          if (tick_s) next_count_s = count_r + WIDTH'(1);
          else        next_count_s = count_r;
          if (next_state_s == DONE) next_done_s = grant_r;
          else                      next_done_s = 4'd0;
        end
      end
      DONE: begin
        next_grant_s = 4'd0;
        next_last_s  = sel_r;
      end
      default: begin
        next_grant_s = 4'd0;
      end
    endcase
  end

endmodule

// File: doc/delay_scheduler.md
DELAY_SCHEDULER -- requirements
Module: delay_scheduler

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, which sets the counter and delay width in bits.
REQ-002 The block SHALL have port clock, input, 1 bit: the system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-004 The block SHALL have port req, input, 4 bits: per-requester delay request, held high until done or abort.
REQ-005 The block SHALL have port delay, input, 4*WIDTH bits: requester i's delay at [i*WIDTH +: WIDTH].
REQ-006 The block SHALL have port grant, output, 4 bits: one-hot owner of the shared counter; all zero when idle.
REQ-007 The block SHALL have port done, output, 4 bits: one-hot, one-cycle completion pulse.
REQ-008 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-009 The block SHALL have port count, output, WIDTH bits: the shared up-counter value.

Function
REQ-010 The block SHALL implement FSM states IDLE, LOAD, COUNT and DONE, with all outputs registered.
REQ-011 In IDLE with req nonzero, the block SHALL pick sel round-robin, searching from last_grant+1 mod 4, and go to LOAD.
REQ-012 The block SHALL set grant[sel] at the same edge it enters LOAD and hold it through DONE.
REQ-013 In LOAD, the block SHALL latch target = delay[sel], clear count to 0, and go to COUNT, or go to DONE if target == 0.
REQ-014 In COUNT, the block SHALL increment count by 1 per enabled tick and enter DONE at the edge where count becomes target.
REQ-015 Latency: with req sampled at edge k, the block SHALL enter DONE at edge k+1+D (D = latched delay), and done[sel] SHALL be high for exactly that cycle.
REQ-016 When leaving DONE, the block SHALL clear grant, set last_grant = sel and return to IDLE; there SHALL be at least one IDLE cycle between jobs.
REQ-017 Abort: if req[sel] is low in LOAD or COUNT, the block SHALL return to IDLE at the next edge with no done pulse, clear grant and set last_grant = sel.
REQ-018 The block SHALL ignore changes to delay after LOAD; the latched target governs the job.
REQ-019 count SHALL never wrap: max target is 2^WIDTH-1 and the counter stops on match.
REQ-020 count SHALL hold its last value while in IDLE.
REQ-021 Simultaneous requests SHALL be served one at a time in round-robin order; req changes on non-selected lines SHALL have no effect on the current job.
REQ-022 If req[sel] falls in the DONE cycle, the block SHALL still complete normally.

Reset
REQ-023 While reset is high, the block SHALL force state=IDLE, grant=0, done=0, busy=0, count=0, last_grant=3 (so req[0] wins first), and prescaler=0.
REQ-024 Reset mid-job SHALL abort within one edge, with no done pulse.

Configuration
REQ-025 With macro DELAY_SCHED_PRESCALE_EN defined, a 4-bit prescaler cleared in LOAD SHALL enable a count tick only when the prescaler is 15, so DONE is entered at edge k+1+16*D.
REQ-026 Without DELAY_SCHED_PRESCALE_EN, every COUNT cycle SHALL be a tick and no prescaler logic SHALL exist.

Verification
REQ-027 Single job: req=0001, delay0=5, req sampled at edge 10 -> grant=0001 from edge 10, done=0001 only in the cycle after edge 16, busy low after edge 17.
REQ-028 Zero delay: req=0100, delay2=0 -> LOAD goes to DONE; done=0100 one cycle at k+1; count stays 0.
REQ-029 Contention: req=1111 held, all delays=2 after reset -> grants in order 0001, 0010, 0100, 1000, 0001; exactly one done per job.
REQ-030 Abort and reset: req0 delay=200, drop req0 at count=50 -> no done, IDLE next edge; repeat with reset at count=50 -> all outputs 0 next edge.
REQ-031 Width limit and prescale: WIDTH=4, delay=15 -> count reaches 15 and does not wrap; with DELAY_SCHED_PRESCALE_EN, delay=3 -> DONE at k+49.
